rf_pulse_seq: RTL and testbench

Pulse sequencer for the cavity feedback path. Produces the amplitude setpoint ramp and the RF-on gating that the feedback core and the output chain consume, all paced by the master CIC tick. Triggers come from software, an external trigger, or free-run. It also flags pulse boundaries for waveform capture.

---
 rtl/rf_pulse_seq_pkg.sv | 22 ++
 rtl/seq_ramp.sv | 62 ++++++
 rtl/rf_pulse_seq.sv | 194 +++++++++++++++++++
 tb/tb_rf_pulse_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pulse_seq_pkg.sv
// rf_pulse_seq_pkg
// Shared constants for the cavity-feedback pulse sequencer: state encodings
// (also visible on seq_state readback), trig_sel codes and default widths.
// Optional feature macro used by the sequencer: RF_PULSE_SEQ_TAG_EN.
package rf_pulse_seq_pkg;

  localparam int AW_DEFAULT = 18;
  localparam int CW_DEFAULT = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARMED     = 3'd1;
  localparam logic [2:0] ST_RAMP_UP   = 3'd2;
  localparam logic [2:0] ST_FLAT      = 3'd3;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd4;
  localparam logic [2:0] ST_HOLDOFF   = 3'd5;

  localparam logic [1:0] TRIG_SW   = 2'd0;
  localparam logic [1:0] TRIG_EXT  = 2'd1;
  localparam logic [1:0] TRIG_FREE = 2'd2;
  localparam logic [1:0] TRIG_OFF  = 2'd3;

endpackage

// File: rtl/seq_ramp.sv
// seq_ramp
// Saturating up/down accumulator that generates the amplitude setpoint.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   up, down       ramp direction (levels); applied only on a tick
//   tick           CIC pacing strobe
//   step           increment per tick; 0 means jump straight to the bound
//   limit          upper bound for the up ramp
//   value          registered setpoint
//   at_limit       value being produced this cycle equals limit
//   at_zero        value being produced this cycle equals 0
// The flags describe the post-update value so the controller can change
// state on the very tick that reaches the bound.
module seq_ramp
  import rf_pulse_seq_pkg::*;
#(
  parameter int aw = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up,
  input  logic          down,
  input  logic          tick,
  input  logic [aw-1:0] step,
  input  logic [aw-1:0] limit,
  output logic [aw-1:0] value,
  output logic          at_limit,
  output logic          at_zero
);

  logic [aw:0]   sum;
  logic [aw-1:0] value_nxt;

  // Next value: the sum is one bit wider so the clamp against limit
  // never sees a wrapped result.
  always_comb begin
    sum       = {1'b0, value} + {1'b0, step};
    value_nxt = value;
    if (tick && up) begin
      if (step == '0 || sum >= {1'b0, limit})
        value_nxt = limit;
      else
        value_nxt = sum[aw-1:0];
    end else if (tick && down) begin
      if (step == '0 || step >= value)
        value_nxt = '0;
      else
        value_nxt = value - step;
    end
  end

  assign at_limit = (value_nxt == limit);
  assign at_zero  = (value_nxt == '0);

  always_ff @(posedge clk) begin
    if (rst)
      value <= '0;
    else
      value <= value_nxt;
  end

endmodule

// File: rtl/rf_pulse_seq.sv
// rf_pulse_seq
// Pulse sequencer for the cavity feedback path: ramps the amplitude setpoint
// up, holds a flat top, ramps down, then enforces a holdoff, all paced by the
// master CIC tick. Triggers come from software, an external edge or free-run.
// Ports:
//   clk, rst              ADC-domain clock, synchronous active-high reset
//   cic_tick              pacing strobe (1 in 33 clk)
//   sw_trig, ext_trig     software strobe, external level (rising edge used)
//   trig_sel              0 sw, 1 ext, 2 free-run, 3 disabled
//   arm                   host enable; dropping it aborts with a ramp-down
//   amp_flat, ramp_step   pulse amplitude and per-tick step (latched at start)
//   flat_len, holdoff_len flat-top and dead-time lengths in ticks
//   setpoint, rf_on       setpoint to feedback core, RF gate
//   pulse_start/_end      one-cycle boundary strobes for waveform capture
//   seq_state             state readback
//   retrig_count          saturating count of ignored triggers
//   pulse_tag             per-pulse tag, only when RF_PULSE_SEQ_TAG_EN is
//                         defined; otherwise tied to 0
module rf_pulse_seq
  import rf_pulse_seq_pkg::*;
#(
  parameter int aw = AW_DEFAULT,
  parameter int cw = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cic_tick,
  input  logic          sw_trig,
  input  logic          ext_trig,
  input  logic [1:0]    trig_sel,
  input  logic          arm,
  input  logic [aw-1:0] amp_flat,
  input  logic [aw-1:0] ramp_step,
  input  logic [cw-1:0] flat_len,
  input  logic [cw-1:0] holdoff_len,
  output logic [aw-1:0] setpoint,
  output logic          rf_on,
  output logic          pulse_start,
  output logic          pulse_end,
  output logic [2:0]    seq_state,
  output logic [7:0]    retrig_count,
  output logic [7:0]    pulse_tag
);

  logic [2:0]    state, state_nxt;
  logic [cw-1:0] cnt, cnt_nxt;
  logic [aw-1:0] amp_lat, step_lat;
  logic          ext_prev, ext_rise;
  logic          trig, retrig_hit;
  logic          launch, finish;
  logic          ramp_up, ramp_down;
  logic          at_limit, at_zero;

  assign ext_rise = ext_trig & ~ext_prev;

  // Trigger selection. Free-run is a constant request, so it must never
  // feed the ignored-trigger counter.
  always_comb begin
    trig = 1'b0;
    case (trig_sel)
      TRIG_SW:   trig = sw_trig;
      TRIG_EXT:  trig = ext_rise;
      TRIG_FREE: trig = 1'b1;
      default:   trig = 1'b0;
    endcase
    retrig_hit = trig && (state != ST_ARMED) && (trig_sel != TRIG_FREE);
  end

  // The up ramp stops as soon as arm drops so an abort never takes an
  // extra step upward; the down ramp continues regardless of arm.
  assign ramp_up   = (state == ST_RAMP_UP) && arm;
  assign ramp_down = (state == ST_RAMP_DOWN);

  seq_ramp #(.aw(aw)) u_ramp (
    .clk      (clk),
    .rst      (rst),
    .up       (ramp_up),
    .down     (ramp_down),
    .tick     (cic_tick),
    .step     (step_lat),
    .limit    (amp_lat),
    .value    (setpoint),
    .at_limit (at_limit),
    .at_zero  (at_zero)
  );

  // Sequencer next state. The shared counter holds the flat-top length in
  // FLAT and the dead time in HOLDOFF; both exit on a tick that finds it 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm)
          state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          state_nxt = ST_IDLE;
        end else if (trig) begin
          state_nxt = ST_RAMP_UP;
          launch    = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if (!arm) begin
          state_nxt = ST_RAMP_DOWN;
        end else if (cic_tick && at_limit) begin
          state_nxt = ST_FLAT;
          cnt_nxt   = flat_len;
        end
      end
      ST_FLAT: begin
        if (!arm) begin
          state_nxt = ST_RAMP_DOWN;
        end else if (cic_tick) begin
          if (cnt == '0)
            state_nxt = ST_RAMP_DOWN;
          else
            cnt_nxt = cnt - cw'(1);
        end
      end
      ST_RAMP_DOWN: begin
        if (cic_tick && at_zero) begin
          state_nxt = ST_HOLDOFF;
          cnt_nxt   = holdoff_len;
          finish    = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cic_tick) begin
          if (cnt == '0)
            state_nxt = arm ? ST_ARMED : ST_IDLE;
          else
            cnt_nxt = cnt - cw'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered state, pulse parameters, gating and strobes. Amplitude and
  // step are captured once at launch so host writes mid-pulse are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      amp_lat      <= '0;
      step_lat     <= '0;
      ext_prev     <= 1'b0;
      rf_on        <= 1'b0;
      pulse_start  <= 1'b0;
      pulse_end    <= 1'b0;
      retrig_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ext_prev    <= ext_trig;
      pulse_start <= launch;
      pulse_end   <= finish;
      if (launch) begin
        amp_lat  <= amp_flat;
        step_lat <= ramp_step;
        rf_on    <= 1'b1;
      end else if (finish) begin
        rf_on <= 1'b0;
      end
      if (retrig_hit && retrig_count != 8'hFF)
        retrig_count <= retrig_count + 8'd1;
    end
  end

  assign seq_state = state;

`ifdef RF_PULSE_SEQ_TAG_EN
  logic [7:0] tag_q;

  // Tag advances together with pulse_start so capture logic sees the new
  // pulse's tag on the same cycle as the start strobe.
  always_ff @(posedge clk) begin
    if (rst)
      tag_q <= 8'd0;
    else if (launch)
      tag_q <= tag_q + 8'd1;
  end

  assign pulse_tag = tag_q;
`else
  assign pulse_tag = 8'd0;
`endif

endmodule

// File: tb/tb_rf_pulse_seq.sv
// tb_rf_pulse_seq
// Directed bench for rf_pulse_seq. Inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge between.
module tb_rf_pulse_seq;

  localparam int AW = 18;
  localparam int CW = 16;
  localparam int TICK_GAP = 4;
`ifdef RF_PULSE_SEQ_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cic_tick;
  logic          sw_trig;
  logic          ext_trig;
  logic [1:0]    trig_sel;
  logic          arm;
  logic [AW-1:0] amp_flat;
  logic [AW-1:0] ramp_step;
  logic [CW-1:0] flat_len;
  logic [CW-1:0] holdoff_len;
  logic [AW-1:0] setpoint;
  logic          rf_on;
  logic          pulse_start;
  logic          pulse_end;
  logic [2:0]    seq_state;
  logic [7:0]    retrig_count;
  logic [7:0]    pulse_tag;

  int numAsserts = 0;
  int numFails   = 0;

  rf_pulse_seq #(.aw(AW), .cw(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cic_tick     (cic_tick),
    .sw_trig      (sw_trig),
    .ext_trig     (ext_trig),
    .trig_sel     (trig_sel),
    .arm          (arm),
    .amp_flat     (amp_flat),
    .ramp_step    (ramp_step),
    .flat_len     (flat_len),
    .holdoff_len  (holdoff_len),
    .setpoint     (setpoint),
    .rf_on        (rf_on),
    .pulse_start  (pulse_start),
    .pulse_end    (pulse_end),
    .seq_state    (seq_state),
    .retrig_count (retrig_count),
    .pulse_tag    (pulse_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numAsserts++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CIC tick preceded by a few quiet cycles.
  task automatic applyStimulus();
    repeat (TICK_GAP - 1) @(negedge clk);
    cic_tick = 1'b1;
    @(negedge clk);
    cic_tick = 1'b0;
  endtask

  task automatic swTrig();
    sw_trig = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0;
  endtask

  task automatic checkTick(input string tag, input int sp, input int st);
    applyStimulus();
    checkOutput({tag, "_sp"}, 32'(setpoint), sp);
    checkOutput({tag, "_st"}, 32'(seq_state), st);
  endtask

  function automatic int tagExp(input int n);
    return TAG_EN ? n : 0;
  endfunction

  initial begin
    rst = 1'b1; cic_tick = 1'b0; sw_trig = 1'b0; ext_trig = 1'b0;
    trig_sel = 2'd0; arm = 1'b0; amp_flat = '0; ramp_step = '0;
    flat_len = '0; holdoff_len = '0;

    // ---- reset values
    idleCycles(3);
    checkOutput("rst_state", 32'(seq_state), 0);
    checkOutput("rst_sp", 32'(setpoint), 0);
    checkOutput("rst_rfon", 32'(rf_on), 0);
    checkOutput("rst_pstart", 32'(pulse_start), 0);
    checkOutput("rst_pend", 32'(pulse_end), 0);
    checkOutput("rst_retrig", 32'(retrig_count), 0);
    checkOutput("rst_tag", 32'(pulse_tag), 0);

    // ---- basic pulse: 1000 / 300, flat 2, holdoff 3
    rst = 1'b0; arm = 1'b1; amp_flat = 18'd1000; ramp_step = 18'd300;
    flat_len = 16'd2; holdoff_len = 16'd3;
    idleCycles(1);
    checkOutput("p1_armed", 32'(seq_state), 1);
    swTrig();
    checkOutput("p1_launch_st", 32'(seq_state), 2);
    checkOutput("p1_pstart", 32'(pulse_start), 1);
    checkOutput("p1_rfon", 32'(rf_on), 1);
    checkOutput("p1_sp0", 32'(setpoint), 0);
    checkOutput("p1_tag", 32'(pulse_tag), tagExp(1));
    idleCycles(1);
    checkOutput("p1_pstart_clr", 32'(pulse_start), 0);
    checkTick("p1_up1", 300, 2);
    checkTick("p1_up2", 600, 2);
    checkTick("p1_up3", 900, 2);
    checkTick("p1_up4", 1000, 3);
    checkTick("p1_flat1", 1000, 3);
    checkTick("p1_flat2", 1000, 3);
    checkTick("p1_flat3", 1000, 4);
    checkTick("p1_dn1", 700, 4);
    checkOutput("p1_dn_rfon", 32'(rf_on), 1);
    checkTick("p1_dn2", 400, 4);
    checkTick("p1_dn3", 100, 4);
    checkTick("p1_dn4", 0, 5);
    checkOutput("p1_end_rfon", 32'(rf_on), 0);
    checkOutput("p1_pend", 32'(pulse_end), 1);
    idleCycles(1);
    checkOutput("p1_pend_clr", 32'(pulse_end), 0);
    checkTick("p1_ho1", 0, 5);
    checkTick("p1_ho2", 0, 5);
    checkTick("p1_ho3", 0, 5);
    checkTick("p1_ho4", 0, 1);

    // ---- instant step, trigger coincident with tick, config change mid-pulse
    amp_flat = 18'd5000; ramp_step = 18'd0; flat_len = 16'd0; holdoff_len = 16'd0;
    sw_trig = 1'b1; cic_tick = 1'b1;
    @(negedge clk);
    sw_trig = 1'b0; cic_tick = 1'b0;
    checkOutput("p2_coinc_st", 32'(seq_state), 2);
    checkOutput("p2_coinc_sp", 32'(setpoint), 0);
    checkOutput("p2_tag", 32'(pulse_tag), tagExp(2));
    amp_flat = 18'd7;
    checkTick("p2_jump", 5000, 3);
    checkTick("p2_flat", 5000, 4);
    checkTick("p2_drop", 0, 5);
    checkOutput("p2_pend", 32'(pulse_end), 1);
    checkTick("p2_ho", 0, 1);

    // ---- abort at 600 during ramp-up
    amp_flat = 18'd1000; ramp_step = 18'd300; flat_len = 16'd2; holdoff_len = 16'd1;
    swTrig();
    checkOutput("p3_launch", 32'(seq_state), 2);
    checkTick("p3_up1", 300, 2);
    checkTick("p3_up2", 600, 2);
    arm = 1'b0;
    idleCycles(1);
    checkOutput("p3_abort_st", 32'(seq_state), 4);
    checkOutput("p3_abort_sp", 32'(setpoint), 600);
    checkTick("p3_dn1", 300, 4);
    checkTick("p3_dn2", 0, 5);
    checkOutput("p3_pend", 32'(pulse_end), 1);
    checkTick("p3_ho1", 0, 5);
    checkTick("p3_ho2", 0, 0);

    // ---- ignored triggers during FLAT and HOLDOFF
    arm = 1'b1; amp_flat = 18'd300; ramp_step = 18'd300;
    flat_len = 16'd2; holdoff_len = 16'd1;
    idleCycles(1);
    checkOutput("p4_armed", 32'(seq_state), 1);
    swTrig();
    checkOutput("p4_launch", 32'(seq_state), 2);
    checkTick("p4_up", 300, 3);
    swTrig();
    idleCycles(1);
    swTrig();
    checkOutput("p4_retrig2", 32'(retrig_count), 2);
    checkTick("p4_flat1", 300, 3);
    checkTick("p4_flat2", 300, 3);
    checkTick("p4_flat3", 300, 4);
    checkTick("p4_dn", 0, 5);
    swTrig();
    checkOutput("p4_retrig3", 32'(retrig_count), 3);
    checkOutput("p4_no_pulse", 32'(seq_state), 5);
    checkTick("p4_ho1", 0, 5);
    checkTick("p4_ho2", 0, 1);
    checkOutput("p4_retrig3_hold", 32'(retrig_count), 3);

    // ---- saturation: hold sw_trig for 300 cycles in IDLE
    arm = 1'b0;
    idleCycles(1);
    checkOutput("sat_idle", 32'(seq_state), 0);
    sw_trig = 1'b1;
    idleCycles(300);
    sw_trig = 1'b0;
    checkOutput("sat_255", 32'(retrig_count), 255);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    checkOutput("sat_rst_clr", 32'(retrig_count), 0);

    // ---- free-run back-to-back, flat 0 holdoff 0
    trig_sel = 2'd2; arm = 1'b1; amp_flat = 18'd300; ramp_step = 18'd300;
    flat_len = 16'd0; holdoff_len = 16'd0;
    idleCycles(1);
    checkOutput("fr_armed", 32'(seq_state), 1);
    idleCycles(1);
    checkOutput("fr_launch1", 32'(seq_state), 2);
    checkOutput("fr_pstart1", 32'(pulse_start), 1);
    checkOutput("fr_tag1", 32'(pulse_tag), tagExp(1));
    checkTick("fr_up", 300, 3);
    checkTick("fr_flat", 300, 4);
    checkTick("fr_dn", 0, 5);
    checkOutput("fr_rfoff", 32'(rf_on), 0);
    checkOutput("fr_pend", 32'(pulse_end), 1);
    amp_flat = 18'd1000; flat_len = 16'd5;
    checkTick("fr_ho", 0, 1);
    checkOutput("fr_rfoff2", 32'(rf_on), 0);
    idleCycles(1);
    checkOutput("fr_launch2", 32'(seq_state), 2);
    checkOutput("fr_rfon2", 32'(rf_on), 1);
    checkOutput("fr_pstart2", 32'(pulse_start), 1);
    checkOutput("fr_tag2", 32'(pulse_tag), tagExp(2));
    checkOutput("fr_no_retrig", 32'(retrig_count), 0);
    trig_sel = 2'd3;

    // ---- reset in FLAT at 1000
    checkTick("rf_up1", 300, 2);
    checkTick("rf_up2", 600, 2);
    checkTick("rf_up3", 900, 2);
    checkTick("rf_up4", 1000, 3);
    checkTick("rf_flat", 1000, 3);
    rst = 1'b1;
    idleCycles(1);
    checkOutput("rf_sp", 32'(setpoint), 0);
    checkOutput("rf_rfon", 32'(rf_on), 0);
    checkOutput("rf_st", 32'(seq_state), 0);
    checkOutput("rf_pend", 32'(pulse_end), 0);
    checkOutput("rf_tag", 32'(pulse_tag), 0);
    rst = 1'b0;

    // ---- external trigger: rising edge only, edges outside ARMED counted
    trig_sel = 2'd1; arm = 1'b1; ext_trig = 1'b0;
    idleCycles(1);
    checkOutput("ext_armed", 32'(seq_state), 1);
    ext_trig = 1'b1;
    idleCycles(1);
    checkOutput("ext_launch", 32'(seq_state), 2);
    checkOutput("ext_pstart", 32'(pulse_start), 1);
    idleCycles(2);
    checkOutput("ext_level_noretrig", 32'(retrig_count), 0);
    ext_trig = 1'b0;
    idleCycles(1);
    ext_trig = 1'b1;
    idleCycles(1);
    checkOutput("ext_edge_retrig", 32'(retrig_count), 1);
    checkOutput("ext_still_up", 32'(seq_state), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
